// File: rtl/raymarch_pkg.sv
// Shared constants and types for the raymarch frame scheduler.
package raymarch_pkg;

  localparam int unsigned CORDW     = 10;
  localparam int unsigned COLOR_W   = 10;
  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/rm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over req, starting at a registered pointer
// that moves past the granted index when advance is high.
module rm_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic          found;

  // First requester at or after ptr, wrapping
  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = (32'(idx) == N - 1) ? '0 : idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/raymarch_scheduler.sv
// Frame sequencer: raster-order pixel dispatch to NUM_CORES cores and result
// arbitration onto one framebuffer write port. Optional RAYMARCH_SCHED_PERF_EN.
module raymarch_scheduler
  import raymarch_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned H_RES     = H_RES_DEF,
  parameter int unsigned V_RES     = V_RES_DEF,
  parameter int unsigned CORDW     = raymarch_pkg::CORDW,
  parameter int unsigned COLOR_W   = raymarch_pkg::COLOR_W,
  parameter int unsigned ADDR_W    = 19
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         frame_done,
  output logic [NUM_CORES-1:0]         disp_valid,
  input  logic [NUM_CORES-1:0]         disp_ready,
  output logic [CORDW-1:0]             disp_x,
  output logic [CORDW-1:0]             disp_y,
  input  logic [NUM_CORES-1:0]         res_valid,
  output logic [NUM_CORES-1:0]         res_ready,
  input  logic [NUM_CORES*CORDW-1:0]   res_x,
  input  logic [NUM_CORES*CORDW-1:0]   res_y,
  input  logic [NUM_CORES*COLOR_W-1:0] res_color,
  output logic                         fb_we,
  output logic [ADDR_W-1:0]            fb_addr,
  output logic [COLOR_W-1:0]           fb_data,
  output logic [31:0]                  frame_cycles
);

  sched_state_t         state, state_next;
  logic [NUM_CORES-1:0] core_busy;
  logic [NUM_CORES-1:0] offer_req;
  logic [NUM_CORES-1:0] disp_pick;
  logic [NUM_CORES-1:0] res_gnt;
  logic                 hs;
  logic                 last_pix;
  logic                 accept;
  logic [CORDW-1:0]     sel_x, sel_y;
  logic [COLOR_W-1:0]   sel_col;
  logic [ADDR_W-1:0]    addr_c;

  assign hs       = |(disp_valid & disp_ready);
  assign last_pix = (disp_x == CORDW'(H_RES - 1)) && (disp_y == CORDW'(V_RES - 1));

  // New offer only when nothing is pending or the pending one completes now
  assign offer_req = (state == DISPATCH && (disp_valid == '0 || (hs && !last_pix)))
                   ? (~core_busy & ~disp_valid) : '0;

  rm_rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (offer_req),
    .advance (|disp_pick),
    .gnt     (disp_pick)
  );

  rm_rr_arbiter #(.N(NUM_CORES)) u_res_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (res_valid),
    .advance (accept),
    .gnt     (res_gnt)
  );

  assign res_ready = res_gnt;
  assign accept    = |res_gnt;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = DISPATCH;
      DISPATCH: if (hs && last_pix) state_next = DRAIN;
      DRAIN:    if (core_busy == '0 && !fb_we) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != IDLE);
      frame_done <= (state_next == DONE);
    end
  end

  // Offer register doubles as the raster pixel counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_valid <= '0;
      disp_x     <= '0;
      disp_y     <= '0;
      core_busy  <= '0;
    end else begin
      if (hs || disp_valid == '0) disp_valid <= disp_pick;
      core_busy <= (core_busy | (disp_valid & disp_ready)) & ~res_gnt;
      if (state == IDLE && start) begin
        disp_x <= '0;
        disp_y <= '0;
      end else if (hs) begin
        if (disp_x == CORDW'(H_RES - 1)) begin
          disp_x <= '0;
          disp_y <= disp_y + CORDW'(1);
        end else begin
          disp_x <= disp_x + CORDW'(1);
        end
      end
    end
  end

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_col = '0;
    for (int unsigned c = 0; c < NUM_CORES; c++) begin
      if (res_gnt[c]) begin
        sel_x   |= res_x[c*CORDW +: CORDW];
        sel_y   |= res_y[c*CORDW +: CORDW];
        sel_col |= res_color[c*COLOR_W +: COLOR_W];
      end
    end
  end

  assign addr_c = ADDR_W'(32'(sel_y) * H_RES + 32'(sel_x));

  // Results accepted while idle are consumed but never written
  always_ff @(posedge clk) begin
    if (!reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= accept && (state != IDLE);
      if (accept && state != IDLE) begin
        fb_addr <= addr_c;
        fb_data <= sel_col;
      end
    end
  end

`ifdef RAYMARCH_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cycles <= '0;
    end else if (state == IDLE && start) begin
      frame_cycles <= 32'd1;
    end else if (state != IDLE) begin
      frame_cycles <= frame_cycles + 32'd1;
    end
  end
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Scoreboard bench for raymarch_scheduler on a 4x2 frame with 4 modelled cores.
module tb_raymarch_scheduler;
  import raymarch_pkg::*;

  localparam int NC   = 4;
  localparam int HR   = 4;
  localparam int VR   = 2;
  localparam int AW   = 3;
  localparam int NPIX = HR * VR;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  busy, frame_done;
  logic [NC-1:0]         disp_valid, disp_ready, res_valid, res_ready;
  logic [CORDW-1:0]      disp_x, disp_y;
  logic [NC*CORDW-1:0]   res_x, res_y;
  logic [NC*COLOR_W-1:0] res_color;
  logic                  fb_we;
  logic [AW-1:0]         fb_addr;
  logic [COLOR_W-1:0]    fb_data;
  logic [31:0]           frame_cycles;

  always #5 clk = ~clk;

  raymarch_scheduler #(
    .NUM_CORES(NC), .H_RES(HR), .V_RES(VR),
    .CORDW(CORDW), .COLOR_W(COLOR_W), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_x(disp_x), .disp_y(disp_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_color(res_color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .frame_cycles(frame_cycles)
  );

  typedef struct { int addr; int data; } wr_t;

  // Core models: 0 idle, 1 computing, 2 holding a result
  int               core_st[NC];
  int               core_cnt[NC];
  logic [CORDW-1:0] core_x[NC], core_y[NC];
  logic [COLOR_W-1:0] core_col[NC];

  bit  rdy_rand, hold_res, block0;
  int  lat_min = 1, lat_max = 1;
  int  checks, errors;
  wr_t exp_q[$];
  int  wr_cnt[NPIX];
  int  fd_cnt, disp_cnt, px, py, cyc, s_cyc, d_cyc;
  logic [NC-1:0]    prev_dv;
  logic [CORDW-1:0] prev_x, prev_y;
  bit               prev_hs;
  logic [NC-1:0]    acc_log[$];

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < NC; c++) begin
      res_valid[c] = (core_st[c] == 2);
      res_x[c*CORDW +: CORDW] = core_x[c];
      res_y[c*CORDW +: CORDW] = core_y[c];
      res_color[c*COLOR_W +: COLOR_W] = core_col[c];
      disp_ready[c] = (core_st[c] == 0) && !(block0 && c == 0) &&
                      (!rdy_rand || $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic clear_models();
    for (int c = 0; c < NC; c++) begin
      core_st[c] = 0; core_cnt[c] = 0; core_x[c] = '0; core_y[c] = '0; core_col[c] = '0;
    end
    exp_q.delete();
    prev_dv = '0;
    prev_hs = 1'b0;
    drive_inputs();
  endtask

  // Scoreboard monitor: every framebuffer write must match the oldest expectation
  always @(negedge clk) begin
    if (fb_we) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fb_unexpected addr=%0d data=%0d required=no write", fb_addr, fb_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("fb_addr", int'(fb_addr), e.addr);
        check("fb_data", int'(fb_data), e.data);
      end
      wr_cnt[int'(fb_addr)]++;
    end
  end

  // One clock: observe handshakes at the negedge, advance the core models after the edge
  task automatic step();
    logic [NC-1:0]    hs, acc, busy_mask;
    logic [CORDW-1:0] hx, hy;
    @(negedge clk);
    cyc++;
    hs  = disp_valid & disp_ready;
    acc = res_valid & res_ready;
    hx  = disp_x;
    hy  = disp_y;
    for (int c = 0; c < NC; c++) busy_mask[c] = (core_st[c] != 0);
    if (prev_dv != '0 && !prev_hs) begin
      check("disp_hold_valid", int'(disp_valid), int'(prev_dv));
      check("disp_hold_xy", int'({disp_y, disp_x}), int'({prev_y, prev_x}));
    end
    if (disp_valid != '0) begin
      check("disp_onehot", $countones(disp_valid), 1);
      check("disp_to_idle_core", int'(disp_valid & busy_mask), 0);
    end
    if (res_ready != '0) begin
      check("res_onehot", $countones(res_ready), 1);
      check("res_grant_subset", int'(res_ready & ~res_valid), 0);
    end
    if (hs != '0) begin
      disp_cnt++;
      check("disp_x", int'(hx), px);
      check("disp_y", int'(hy), py);
      px++;
      if (px == HR) begin px = 0; py++; end
    end
    for (int c = 0; c < NC; c++) begin
      if (acc[c] && busy) exp_q.push_back('{int'(core_y[c]) * HR + int'(core_x[c]), int'(core_col[c])});
    end
    if (acc != '0) acc_log.push_back(acc);
    if (start && !busy) begin px = 0; py = 0; s_cyc = cyc; end
    if (frame_done) begin fd_cnt++; d_cyc = cyc; end
    prev_dv = disp_valid; prev_x = disp_x; prev_y = disp_y; prev_hs = (hs != '0);
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (hs[c]) begin
        core_st[c] = 1; core_cnt[c] = int'($urandom_range(lat_min, lat_max));
        core_x[c] = hx; core_y[c] = hy; core_col[c] = COLOR_W'($urandom);
      end else if (acc[c]) begin
        core_st[c] = 0;
      end else if (core_st[c] == 1) begin
        core_cnt[c]--;
        if (core_cnt[c] <= 0 && !hold_res) core_st[c] = 2;
      end
    end
    drive_inputs();
  endtask

  task automatic begin_frame();
    for (int a = 0; a < NPIX; a++) wr_cnt[a] = 0;
    fd_cnt = 0; disp_cnt = 0;
    acc_log.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", int'(busy), 1);
  endtask

  task automatic finish_frame(input int budget);
    int n = 0;
    while (fd_cnt == 0 && n < budget) begin step(); n++; end
    if (fd_cnt == 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout actual=no frame_done required=frame_done within %0d cycles", budget);
    end
    repeat (4) step();
    check("frame_done_count", fd_cnt, 1);
    check("dispatch_count", disp_cnt, NPIX);
    for (int a = 0; a < NPIX; a++) check("addr_written_once", wr_cnt[a], 1);
    check("pending_writes", exp_q.size(), 0);
    check("idle_after_frame", int'(busy), 0);
`ifdef RAYMARCH_SCHED_PERF_EN
    check("frame_cycles", int'(frame_cycles), d_cyc - s_cyc + 1);
`else
    check("frame_cycles", int'(frame_cycles), 0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0;
    rdy_rand = 0; hold_res = 0; block0 = 0;
    clear_models();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_disp_valid", int'(disp_valid), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_frame_cycles", int'(frame_cycles), 0);
    @(posedge clk); #1;

    // Frame 1: stalled first offer, then four held results released together
    block0 = 1; hold_res = 1; lat_min = 1; lat_max = 1;
    begin_frame();
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", int'(disp_valid), 1);
      check("stall_xy", int'({disp_y, disp_x}), 0);
    end
    block0 = 0;
    n = 0;
    while (disp_cnt < 4 && n < 30) begin step(); n++; end
    check("four_dispatched", disp_cnt, 4);
    repeat (2) step();
    hold_res = 0;
    acc_log.delete();
    n = 0;
    while (acc_log.size() < 4 && n < 20) begin step(); n++; end
    check("grant_count", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check("grant_order", int'(acc_log[i]), 1 << i);
    finish_frame(300);

    // Frame 2: random ready/latency, start pulsed mid-frame must be ignored
    rdy_rand = 1; lat_min = 1; lat_max = 5;
    begin_frame();
    repeat (6) step();
    start = 1'b1;
    step();
    start = 1'b0;
    finish_frame(400);

    // Frame 3: always-ready cores, 3-cycle reply
    rdy_rand = 0; lat_min = 3; lat_max = 3;
    begin_frame();
    finish_frame(300);

    // Stray result while idle: accepted, never written
    core_st[2] = 2; core_x[2] = CORDW'(1); core_y[2] = CORDW'(1); core_col[2] = COLOR_W'(99);
    drive_inputs();
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_no_write", int'(fb_we), 0);
    end
    check("idle_result_consumed", core_st[2], 0);

    // Reset for three cycles in the middle of dispatch
    rdy_rand = 1; lat_min = 1; lat_max = 3;
    begin_frame();
    repeat (4) step();
    fd_cnt = 0;
    reset = 1'b0;
    clear_models();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      @(posedge clk);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_disp_valid", int'(disp_valid), 0);
    check("midrst_fb_we", int'(fb_we), 0);
    if (frame_done) fd_cnt++;
    check("midrst_no_done", fd_cnt, 0);
    @(posedge clk); #1;

    // Frames after reset with mixed settings
    for (int f = 0; f < 3; f++) begin
      rdy_rand = (f != 1); lat_min = 1; lat_max = 1 + 2 * f;
      begin_frame();
      finish_frame(400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
